// File: rtl/pc_unit_if.sv
// Fetch-stage PC bus: next-PC controls from datapath/hazard unit in, PC state out.
interface pc_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             pc_write;
    logic             redirect_valid;
    logic [WIDTH-1:0] redirect_target;
    logic             exc_valid;
    logic [WIDTH-1:0] pc;
    logic [WIDTH-1:0] epc;
    logic             redirect_pending;
    logic             misalign;

    modport master (
        output pc_write, redirect_valid, redirect_target, exc_valid,
        input  pc, epc, redirect_pending, misalign
    );

    modport slave (
        input  pc_write, redirect_valid, redirect_target, exc_valid,
        output pc, epc, redirect_pending, misalign
    );
endinterface

// File: rtl/pc_unit.sv
// Program counter with increment, prioritised exception/redirect, stall-buffered redirect and EPC.
// Optional target alignment trap enabled by defining PC_ALIGN_CHECK_EN.
module pc_unit #(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(32'h0000_0180),
    parameter int unsigned      STEP         = 4
) (
    input  logic      clk,
    input  logic      rst,
    pc_unit_if.slave  bus
);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic [WIDTH-1:0] pend_target_q, pend_target_d;
    logic             pend_valid_q, pend_valid_d;

    logic             load_en;
    logic [WIDTH-1:0] load_target;

`ifdef PC_ALIGN_CHECK_EN
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(STEP - 1);
    logic misalign_q, misalign_d;
    logic target_misaligned;
`endif

    // A live redirect beats a buffered one; either only loads when the PC may advance.
    always_comb begin
        load_en     = bus.pc_write && (bus.redirect_valid || pend_valid_q);
        load_target = bus.redirect_valid ? bus.redirect_target : pend_target_q;
    end

`ifdef PC_ALIGN_CHECK_EN
    assign target_misaligned = |(load_target & ALIGN_MASK);
`endif

    // Next-state selection in priority order: exception, load, increment, buffer, hold.
    always_comb begin
        pc_d          = pc_q;
        epc_d         = epc_q;
        pend_valid_d  = pend_valid_q;
        pend_target_d = pend_target_q;
`ifdef PC_ALIGN_CHECK_EN
        misalign_d    = 1'b0;
`endif
        if (bus.exc_valid) begin
            pc_d         = EXC_VECTOR;
            epc_d        = pc_q;
            pend_valid_d = 1'b0;
        end else if (load_en) begin
            pend_valid_d = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
            if (target_misaligned) begin
                pc_d       = EXC_VECTOR;
                epc_d      = pc_q;
                misalign_d = 1'b1;
            end else begin
                pc_d = load_target;
            end
`else
            pc_d = load_target;
`endif
        end else if (bus.pc_write) begin
            pc_d = pc_q + WIDTH'(STEP);
        end else if (bus.redirect_valid) begin
            pend_target_d = bus.redirect_target;
            pend_valid_d  = 1'b1;
        end
    end

    // State register, updated on the falling edge.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            pc_q          <= RESET_VECTOR;
            epc_q         <= '0;
            pend_valid_q  <= 1'b0;
            pend_target_q <= '0;
        end else begin
            pc_q          <= pc_d;
            epc_q         <= epc_d;
            pend_valid_q  <= pend_valid_d;
            pend_target_q <= pend_target_d;
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    always_ff @(negedge clk or posedge rst) begin
        if (rst) misalign_q <= 1'b0;
        else     misalign_q <= misalign_d;
    end
    assign bus.misalign = misalign_q;
`else
    assign bus.misalign = 1'b0;
`endif

    assign bus.pc               = pc_q;
    assign bus.epc              = epc_q;
    assign bus.redirect_pending = pend_valid_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: stimulus pushes model predictions, a monitor pops and compares.
module tb_pc_unit;

    localparam logic [31:0] EXC_V = 32'h0000_0180;
`ifdef PC_ALIGN_CHECK_EN
    localparam bit ALIGN_CHK = 1'b1;
`else
    localparam bit ALIGN_CHK = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] epc;
        logic        pend;
        logic        mis;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    bit   done = 1'b0;

    pc_unit_if #(.WIDTH(32)) bus ();

    pc_unit #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0),
        .EXC_VECTOR   (EXC_V),
        .STEP         (4)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    // Reference model: architectural PC, EPC and a queue holding at most one buffered redirect.
    logic [31:0] m_pc;
    logic [31:0] m_epc;
    logic [31:0] m_pend[$];

    function automatic exp_t snap(input logic mis);
        exp_t e;
        e.pc   = m_pc;
        e.epc  = m_epc;
        e.pend = (m_pend.size() != 0);
        e.mis  = mis;
        return e;
    endfunction

    task automatic do_reset();
        @(posedge clk); #1;
        m_pc  = 32'h0;
        m_epc = 32'h0;
        m_pend.delete();
        // One check right after the asynchronous assertion, one after the held falling edge.
        exp_q.push_back(snap(1'b0));
        exp_q.push_back(snap(1'b0));
        bus.pc_write        = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;
        bus.exc_valid       = 1'b0;
        rst = 1'b1;
    endtask

    task automatic step(input bit pw, input bit rv, input logic [31:0] rt, input bit ev);
        logic [31:0] tgt;
        logic        mis;
        @(posedge clk); #1;
        rst                 = 1'b0;
        bus.pc_write        = pw;
        bus.redirect_valid  = rv;
        bus.redirect_target = rt;
        bus.exc_valid       = ev;
        mis = 1'b0;
        if (ev) begin
            m_epc = m_pc;
            m_pc  = EXC_V;
            m_pend.delete();
        end else if (pw && (rv || m_pend.size() != 0)) begin
            tgt = rv ? rt : m_pend[0];
            m_pend.delete();
            if (ALIGN_CHK && (tgt % 4 != 0)) begin
                m_epc = m_pc;
                m_pc  = EXC_V;
                mis   = 1'b1;
            end else begin
                m_pc = tgt;
            end
        end else if (pw) begin
            m_pc = m_pc + 32'd4;
        end else if (rv) begin
            m_pend.delete();
            m_pend.push_back(rt);
        end
        exp_q.push_back(snap(mis));
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
        end
    endtask

    // Monitor: after every falling edge or reset assertion, compare outputs with the oldest prediction.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or posedge rst);
            #2;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("pc",               bus.pc,                        e.pc);
                chk("epc",              bus.epc,                       e.epc);
                chk("redirect_pending", {31'b0, bus.redirect_pending}, {31'b0, e.pend});
                chk("misalign",         {31'b0, bus.misalign},         {31'b0, e.mis});
            end
            if (done) begin
                chk("queue_drained", 32'(exp_q.size()), 32'd0);
                $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
                $finish;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        bit          last_rst;
        bit          pw, rv, ev;
        logic [31:0] rt;
        bus.pc_write        = 1'b0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = 32'h0;
        bus.exc_valid       = 1'b0;
        m_pc  = 32'h0;
        m_epc = 32'h0;

        // Sequential fetch, then asynchronous reset mid-cycle.
        do_reset();
        repeat (3) step(1'b1, 1'b0, 32'h0, 1'b0);
        do_reset();

        // Redirects buffered across a stall; the newest wins.
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h100, 1'b0);
        step(1'b0, 1'b1, 32'h200, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);

        // Live redirect overrides a buffered one on release.
        step(1'b0, 1'b1, 32'h200, 1'b0);
        step(1'b1, 1'b1, 32'h300, 1'b0);

        // Exception beats a redirect while stalled.
        step(1'b1, 1'b1, 32'h40, 1'b0);
        step(1'b0, 1'b1, 32'h500, 1'b1);

        // Exception cancels a buffered redirect.
        step(1'b0, 1'b1, 32'h600, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b1);
        step(1'b1, 1'b0, 32'h0, 1'b0);

        // Wrap at the top of the address space.
        step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);

        // Misaligned live target, then a misaligned buffered target.
        step(1'b1, 1'b1, 32'h20, 1'b0);
        step(1'b1, 1'b1, 32'h102, 1'b0);
        step(1'b0, 1'b0, 32'h0, 1'b0);
        step(1'b0, 1'b1, 32'h333, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0);

        // Randomised traffic with occasional resets.
        last_rst = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!last_rst && $urandom_range(63) == 0) begin
                do_reset();
                last_rst = 1'b1;
            end else begin
                pw = ($urandom_range(3) != 0);
                rv = ($urandom_range(3) == 0);
                ev = ($urandom_range(15) == 0);
                rt = $urandom & 32'hFFFF_FFFC;
                if ($urandom_range(7) == 0) rt = rt | 32'($urandom_range(3));
                step(pw, rv, rt, ev);
                last_rst = 1'b0;
            end
        end

        step(1'b0, 1'b0, 32'h0, 1'b0);
        done = 1'b1;
    end

endmodule

// File: doc/pc_unit.md
# pc_unit

Parametrised program-counter unit for the MIPS CPU fetch stage. It replaces the plain load/hold PC register with one that supports:
- its own sequential increment;
- prioritised exception and branch/jump redirects;
- redirects buffered across stalls;
- an exception PC (EPC) capture register.

It sits between the next-PC logic of the datapath and instruction memory. The hazard unit drives its write enable.

## Interface
Parameters:
- WIDTH, 32, width of all address values
- RESET_VECTOR, 0, PC value after reset
- EXC_VECTOR, 32'h0000_0180, PC value loaded on exception
- STEP, 4, sequential increment; must be a power of two ≥ 1

Ports:
- clk  input  1  clock; all state updates on the falling edge
- rst  input  1  asynchronous, active-high reset
- pc_write  input  1  1 = PC may advance; 0 = stall (hold PC)
- redirect_valid  input  1  branch/jump taken this cycle
- redirect_target  input  WIDTH  branch/jump destination
- exc_valid  input  1  exception/interrupt request
- pc  output  WIDTH  current fetch address
- epc  output  WIDTH  PC value at the last exception
- redirect_pending  output  1  a redirect is buffered while stalled
- misalign  output  1  misaligned-target flag (see Configuration)

## Operation
Internal state: pc, epc, pend_valid, pend_target and misalign. pend_valid drives redirect_pending.

On each falling clk edge with rst low, the first matching rule in this order applies:
1. exc_valid=1: pc ← EXC_VECTOR; epc ← current pc; pend_valid ← 0. Applies even when pc_write=0, and even when redirect_valid=1 (the redirect is dropped).
2. pc_write=1 and redirect_valid=1: pc ← redirect_target; pend_valid ← 0. A live redirect overrides a buffered one.
3. pc_write=1 and pend_valid=1: pc ← pend_target; pend_valid ← 0.
4. pc_write=1: pc ← pc + STEP, modulo 2^WIDTH (wraps silently, no flag).
5. pc_write=0 and redirect_valid=1: pc holds; pend_target ← redirect_target; pend_valid ← 1. A newer stalled redirect overwrites an older one.
6. Otherwise: all state holds.

Other rules:
- epc changes only under rule 1.
- pend_target is don't-care while pend_valid=0.

## Timing
- Reset (asynchronous, on rst rising, held while rst=1): pc=RESET_VECTOR, epc=0, redirect_pending=0, misalign=0.
- On the first falling edge after rst drops, rule evaluation proceeds normally.
- All inputs are sampled at the falling edge. Outputs update at that same edge (one edge of latency) and are glitch-free registered values.
- A redirect presented during a stall appears on pc at the first falling edge where pc_write=1 (or is cancelled by an exception).
- redirect_pending rises at the edge the redirect is buffered. It falls at the edge it is consumed or cancelled.
- Reset asserted mid-stall discards any pending redirect.

## Configuration
- PC_ALIGN_CHECK_EN defined:
  - Whenever rule 2 or 3 would load a target whose low log2(STEP) bits are nonzero, the unit does not load it. Instead, for that edge: pc ← EXC_VECTOR; epc ← current pc; pend_valid ← 0; misalign ← 1.
  - misalign is a one-cycle pulse: cleared at the next falling edge.
  - Buffering under rule 5 does not check alignment; the check happens on load.
  - With STEP=1 no target is ever misaligned.
- PC_ALIGN_CHECK_EN undefined: targets load unchecked and misalign is tied to 0.

## Test plan
- Reset, then 3 edges with pc_write=1 and no requests → pc = 0, 4, 8, 12. Assert rst asynchronously mid-cycle → pc=0 immediately.
- pc=8, stall (pc_write=0), redirect to 0x100, then redirect to 0x200 while still stalled → redirect_pending=1 and pc=8 throughout. Release stall → pc=0x200 and redirect_pending=0 on the same edge.
- pending=0x200, release stall with live redirect to 0x300 on the same edge → pc=0x300, pending cleared.
- pc=0x40, exc_valid=1 together with redirect_valid=1 to 0x500 and pc_write=0 → pc=0x180, epc=0x40, redirect_pending=0.
- pc=32'hFFFF_FFFC, pc_write=1 → pc=0 (wrap), no flag.
- With PC_ALIGN_CHECK_EN: pc=0x20, redirect to 0x102 → pc=0x180, epc=0x20, misalign=1 for exactly one cycle. Without PC_ALIGN_CHECK_EN: pc=0x102, misalign=0.
